// File: rtl/midi_cdc_byte_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : midi_cdc_byte_scheduler
//  Description : Source-domain (clkA) controller that shares one pulse-resync
//                byte crossing between the MIDI UART receiver (source 0) and
//                the control/sequencer path (source 1). It arbitrates
//                round-robin, launches each byte as a single-cycle validA
//                pulse, holds dataA/srcA stable for HOLD_CYCLES further
//                cycles and enforces a launch spacing of HOLD_CYCLES+2.
//  Revision    : 1.0 - initial release
// ============================================================================
module midi_cdc_byte_scheduler #(
  // Cycles dataA is held after the launch cycle (legal range 1..255).
  parameter int HOLD_CYCLES = 8
) (
  input  logic       clkA,
  input  logic       rst_n,
  input  logic       en,
  input  logic       valid0,
  input  logic [7:0] data0,
  output logic       ready0,
  input  logic       valid1,
  input  logic [7:0] data1,
  output logic       ready1,
  output logic       validA,
  output logic [7:0] dataA,
  output logic       srcA,
  output logic       busy
);

  // Counter load value: HOLD lasts from this value down to zero inclusive.
  localparam logic [7:0] c_HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t     r_state;
  logic       r_ptr;       // preferred source when both request
  logic [7:0] r_holdCnt;   // remaining HOLD cycles after the current one
  logic       r_validA;
  logic [7:0] r_dataA;
  logic       r_srcA;

  logic       w_canAccept;
  logic       w_grant0;
  logic       w_grant1;
  logic       w_accept;
  logic       w_acceptId;
  logic [7:0] w_acceptData;

  // Arbitration: a lone requester wins, a tie goes to the priority pointer.
  // Reset gates the readies so nothing is granted while rst_n is low.
  always_comb begin
    w_canAccept  = rst_n && en && (r_state == IDLE);
    w_grant0     = w_canAccept && valid0 && (!valid1 || !r_ptr);
    w_grant1     = w_canAccept && valid1 && (!valid0 ||  r_ptr);
    w_accept     = w_grant0 || w_grant1;
    w_acceptId   = w_grant1;
    w_acceptData = w_grant1 ? data1 : data0;
  end

  assign ready0 = w_grant0;
  assign ready1 = w_grant1;
  assign validA = r_validA;
  assign dataA  = r_dataA;
  assign srcA   = r_srcA;
  assign busy   = (r_state != IDLE);

  // Launch/hold sequencer with registered crossing outputs.
  always_ff @(posedge clkA or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ptr     <= 1'b0;
      r_holdCnt <= 8'd0;
      r_validA  <= 1'b0;
      r_dataA   <= 8'h00;
      r_srcA    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_validA <= 1'b0;
          if (w_accept) begin
            r_dataA  <= w_acceptData;
            r_srcA   <= w_acceptId;
            r_ptr    <= ~w_acceptId;
            r_validA <= 1'b1;
            r_state  <= LAUNCH;
          end
        end
        LAUNCH: begin
          r_validA  <= 1'b0;
          r_holdCnt <= c_HOLD_LOAD;
          r_state   <= HOLD;
        end
        HOLD: begin
          r_validA <= 1'b0;
          if (r_holdCnt == 8'd0) begin
            r_state <= IDLE;
          end else begin
            r_holdCnt <= r_holdCnt - 8'd1;
          end
        end
        default: begin
          r_validA <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
